sudoku_uart_tx: RTL and testbench

- Serial transmitter for the Bluetooth UART link. It is the transmit counterpart of the receive path that feeds the top level's bluetooth input.
- Game logic pushes report bytes (cursor moves, cell values, win flag) into a small FIFO. The block serialises them as 8N1 frames, LSB first, on an idle-high line.
- Sits beside the top-level control FSM and drives the Bluetooth module's RX pin.

---
 rtl/sudoku_uart_tx_if.sv | 10 +
 rtl/sudoku_uart_tx.sv | 190 +++++++++++++++++++
 tb/tb_sudoku_uart_tx.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sudoku_uart_tx_if.sv
// Producer-side byte handshake for the Bluetooth UART transmitter.
// A byte moves on any clock edge where data_valid and data_ready are both high.
interface sudoku_uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/sudoku_uart_tx.sv
// Bluetooth UART transmitter: byte FIFO feeding an 8N1, LSB-first serialiser on an idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module sudoku_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  sudoku_uart_tx_if.slave               in_if,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CNTW-1:0] count_q, count_d;
`ifdef UART_TX_PARITY_EN
  logic            parity_q, parity_d;
`endif

  logic       push;
  logic       pop;
  logic       baud_last;
  logic [7:0] head;

  assign in_if.data_ready = (count_q != FULL);
  assign push       = in_if.data_valid && in_if.data_ready;
  assign head       = mem_q[rd_q];
  assign baud_last  = (baud_q == BAUD_LAST);
  assign tx_out     = tx_q;
  assign tx_busy    = (state_q != IDLE) || (count_q != '0);
  assign fifo_count = count_q;

  always_comb begin
    state_d = state_q;
    baud_d  = '0;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Every state change happens on terminal count (or from IDLE at count 0),
    // so the counter only needs to free-run and wrap outside IDLE.
    if (state_q != IDLE && !baud_last) baud_d = baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_last) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (baud_last) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = parity_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_last) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // IDLE and STOP share the same head-of-queue load.
    if (pop) begin
      shift_d = head;
      bit_d   = '0;
      rd_d    = rd_q + 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d = ^head;
`endif
    end

    if (push) begin
      mem_d[wr_q] = in_if.data_in;
      wr_d        = wr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Storage needs no reset: cleared pointers make stale entries unreachable.
  always_ff @(posedge CLK) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_sudoku_uart_tx.sv
// Directed self-checking bench for sudoku_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Honours UART_TX_PARITY_EN for frame length and the parity scenario.
module tb_sudoku_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int FRAME = FB * CPB;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tx_out;
  logic       tx_busy;
  logic [2:0] fifo_count;

  sudoku_uart_tx_if bus();

  sudoku_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .in_if      (bus.slave),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy),
    .fifo_count (fifo_count)
  );

  int checks   = 0;
  int failures = 0;

  bit         rec_on = 1'b0;
  logic       line[$];
  logic [7:0] dec_bytes[$];
  int         dec_starts[$];
  logic       dec_stop[$];
`ifdef UART_TX_PARITY_EN
  logic       dec_par[$];
`endif

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (rec_on) line.push_back(tx_out);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Line level expected during bit slot 'pos' of a frame carrying b.
  function automatic logic exp_level(input logic [7:0] b, input int pos);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9 && FB == 11) return ^b;
    return 1'b1;
  endfunction

  task automatic reset_dut();
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
  endtask

  // Offers b until accepted (bounded); returns just after the accepting edge.
  task automatic push_byte(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge CLK);
      if (bus.data_ready) ok = 1'b1;
      @(posedge CLK);
      #1;
    end
    bus.data_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit && !ok; i++) begin
      @(negedge CLK);
      if (!tx_busy) ok = 1'b1;
    end
  endtask

  // Receiver model: samples each bit mid-slot from the recorded line.
  task automatic decode_line();
    int i = 0;
    dec_bytes.delete();
    dec_starts.delete();
    dec_stop.delete();
`ifdef UART_TX_PARITY_EN
    dec_par.delete();
`endif
    while (i < line.size()) begin
      if (line[i] == 1'b0 && (i + FRAME) <= line.size()) begin
        logic [7:0] b;
        for (int k = 0; k < 8; k++) b[k] = line[i + (k + 1) * CPB + CPB / 2];
        dec_bytes.push_back(b);
        dec_starts.push_back(i);
        dec_stop.push_back(line[i + (FB - 1) * CPB + CPB / 2]);
`ifdef UART_TX_PARITY_EN
        dec_par.push_back(line[i + 9 * CPB + CPB / 2]);
`endif
        i += FRAME;
      end else begin
        i++;
      end
    end
  endtask

  task automatic test_reset();
    int bad;
    RST = 1'b1;
    bus.data_valid = 1'b1;
    bus.data_in    = 8'hFF;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1) begin failures++; $display("FAIL reset_tx_out got=%b exp=1", tx_out); end
    checks++;
    if (bus.data_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", bus.data_ready); end
    checks++;
    if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
    checks++;
    if (fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    bus.data_valid = 1'b0;
    @(posedge CLK);
    #1 RST = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge CLK);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL reset_idle_line bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_single_frame();
    bit ok;
    reset_dut();
    push_byte(8'h35, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL single_accept got=0 exp=1"); end
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1 || fifo_count !== 3'd1 || tx_busy !== 1'b1)
      begin failures++; $display("FAIL single_accept_cycle tx/cnt/busy got=%b/%0d/%b exp=1/1/1", tx_out, fifo_count, tx_busy); end
    for (int k = 0; k < FRAME; k++) begin
      @(negedge CLK);
      checks++;
      if (tx_out !== exp_level(8'h35, k / CPB) || tx_busy !== 1'b1)
        begin failures++; $display("FAIL single_frame cycle=%0d tx/busy got=%b/%b exp=%b/1", k, tx_out, tx_busy, exp_level(8'h35, k / CPB)); end
    end
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== 3'd0)
      begin failures++; $display("FAIL single_end tx/busy/cnt got=%b/%b/%0d exp=1/0/0", tx_out, tx_busy, fifo_count); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    bit ok;
    int acc = 0;
    reset_dut();
    line.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_byte(exp_b[i], ok);
      if (ok) acc++;
    end
    checks++;
    if (acc != 5) begin failures++; $display("FAIL b2b_accepts got=%0d exp=5", acc); end
    @(negedge CLK);
    checks++;
    if (fifo_count !== 3'd4 || bus.data_ready !== 1'b0)
      begin failures++; $display("FAIL b2b_full cnt/ready got=%0d/%b exp=4/0", fifo_count, bus.data_ready); end
    wait_idle(8 * FRAME, ok);
    rec_on = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL b2b_idle_timeout got=busy exp=idle"); end
    decode_line();
    checks++;
    if (dec_bytes.size() != 5) begin
      failures++; $display("FAIL b2b_frames got=%0d exp=5", dec_bytes.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (dec_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, dec_bytes[i], exp_b[i]); end
        checks++;
        if (dec_starts[i] - dec_starts[0] != i * FRAME || dec_stop[i] !== 1'b1)
          begin failures++; $display("FAIL b2b_spacing%0d got_off=%0d exp_off=%0d stop=%b", i, dec_starts[i] - dec_starts[0], i * FRAME, dec_stop[i]); end
      end
    end
  endtask

  task automatic test_full_push();
    logic [7:0] exp_b [6] = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    bit ok;
    int bad = 0;
    reset_dut();
    line.delete();
    rec_on = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(exp_b[i], ok);
    bus.data_in    = 8'hEE;
    bus.data_valid = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      if (fifo_count !== 3'd4 || bus.data_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL full_hold bad_cycles=%0d exp=0", bad); end
    @(posedge CLK);
    #1;
    push_byte(exp_b[5], ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_late_accept got=0 exp=1"); end
    wait_idle(10 * FRAME, ok);
    rec_on = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL full_idle_timeout got=busy exp=idle"); end
    decode_line();
    checks++;
    if (dec_bytes.size() != 6) begin
      failures++; $display("FAIL full_frames got=%0d exp=6", dec_bytes.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (dec_bytes[i] !== exp_b[i]) begin failures++; $display("FAIL full_byte%0d got=%h exp=%h", i, dec_bytes[i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int bad = 0;
    reset_dut();
    push_byte(8'hA5, ok);
    push_byte(8'h3C, ok);
    push_byte(8'hC3, ok);
    repeat (14) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1 || fifo_count !== 3'd2)
      begin failures++; $display("FAIL midrst_bit2 tx/cnt got=%b/%0d exp=1/2", tx_out, fifo_count); end
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b0 || fifo_count !== 3'd2)
      begin failures++; $display("FAIL midrst_bit3 tx/cnt got=%b/%0d exp=0/2", tx_out, fifo_count); end
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0 || bus.data_ready !== 1'b1)
      begin failures++; $display("FAIL midrst_after tx/cnt/busy/ready got=%b/%0d/%b/%b exp=1/0/0/1", tx_out, fifo_count, tx_busy, bus.data_ready); end
    repeat (3 * FRAME) begin
      @(negedge CLK);
      if (tx_out !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL midrst_quiet bad_cycles=%0d exp=0", bad); end
  endtask

  task automatic test_push_at_stop_end();
    bit ok;
    reset_dut();
    line.delete();
    rec_on = 1'b1;
    push_byte(8'h5A, ok);
    repeat (FRAME) @(posedge CLK);
    #1;
    bus.data_in    = 8'h96;
    bus.data_valid = 1'b1;
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1 || fifo_count !== 3'd0 || bus.data_ready !== 1'b1 || tx_busy !== 1'b1)
      begin failures++; $display("FAIL edge_stop tx/cnt/ready/busy got=%b/%0d/%b/%b exp=1/0/1/1", tx_out, fifo_count, bus.data_ready, tx_busy); end
    @(posedge CLK);
    #1 bus.data_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b1 || fifo_count !== 3'd1)
      begin failures++; $display("FAIL edge_idle_gap tx/cnt got=%b/%0d exp=1/1", tx_out, fifo_count); end
    @(negedge CLK);
    checks++;
    if (tx_out !== 1'b0 || fifo_count !== 3'd0)
      begin failures++; $display("FAIL edge_start tx/cnt got=%b/%0d exp=0/0", tx_out, fifo_count); end
    wait_idle(4 * FRAME, ok);
    rec_on = 1'b0;
    decode_line();
    checks++;
    if (dec_bytes.size() != 2) begin
      failures++; $display("FAIL edge_frames got=%0d exp=2", dec_bytes.size());
    end else begin
      checks++;
      if (dec_bytes[0] !== 8'h5A || dec_bytes[1] !== 8'h96)
        begin failures++; $display("FAIL edge_bytes got=%h,%h exp=5a,96", dec_bytes[0], dec_bytes[1]); end
      checks++;
      if (dec_starts[1] - dec_starts[0] != FRAME + 1)
        begin failures++; $display("FAIL edge_spacing got=%0d exp=%0d", dec_starts[1] - dec_starts[0], FRAME + 1); end
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    bit ok;
    reset_dut();
    line.delete();
    rec_on = 1'b1;
    push_byte(8'h35, ok);
    push_byte(8'h07, ok);
    wait_idle(4 * FRAME, ok);
    rec_on = 1'b0;
    decode_line();
    checks++;
    if (dec_bytes.size() != 2) begin
      failures++; $display("FAIL par_frames got=%0d exp=2", dec_bytes.size());
    end else begin
      checks++;
      if (dec_bytes[0] !== 8'h35 || dec_bytes[1] !== 8'h07)
        begin failures++; $display("FAIL par_bytes got=%h,%h exp=35,07", dec_bytes[0], dec_bytes[1]); end
      checks++;
      if (dec_par[0] !== 1'b0 || dec_par[1] !== 1'b1)
        begin failures++; $display("FAIL par_bits got=%b,%b exp=0,1", dec_par[0], dec_par[1]); end
      checks++;
      if (dec_starts[1] - dec_starts[0] != 44)
        begin failures++; $display("FAIL par_spacing got=%0d exp=44", dec_starts[1] - dec_starts[0]); end
    end
  endtask
`endif

  initial begin
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_full_push();
    test_reset_mid_frame();
    test_push_at_stop_end();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
